// File: rtl/path_math.sv
// path_math: from the rover's polar position, its heading and a polar target, computes the CCW turn (15 deg units) and the distance.
// Latency: 22 cycles from the enable edge to the done cycle; 2 cycles when an input is out of range.
// Handshake: enable is taken only in IDLE while done is low; busy covers LOAD..REPORT, and inputs are latched at start.
module path_math (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] r_theta_current,
  input  logic [11:0] r_theta_target,
  input  logic [4:0]  orientation_current,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [4:0]  turn,
  output logic [9:0]  distance
);

  typedef enum logic [3:0] {IDLE, LOAD, PTC, DELTA, SQUARE, ANGLE, SQRT, TURN, REPORT} state_t;
  state_t state;

  // Latched operands
  logic [7:0]        r_cur, r_tgt;
  logic [3:0]        t_cur, t_tgt;
  logic [4:0]        orient;

  // Pipeline registers
  logic signed [8:0] x_cur, y_cur, x_tgt, y_tgt;
  logic signed [9:0] dx, dy;
  logic [8:0]        adx, ady;
  logic              dx_neg, dy_neg;
  logic [3:0]        cnt;
  logic [2:0]        s;
  logic [19:0]       sq_sh;
  logic [11:0]       rem;
  logic [9:0]        root;
  logic [4:0]        turn_r;

  // Combinational helpers
  logic              invalid;
  logic signed [8:0] x_cur_c, y_cur_c, x_tgt_c, y_tgt_c;
  logic [8:0]        abs_dx, abs_dy;
  logic [19:0]       sq_c;
  logic [19:0]       dy_scaled, dx_scaled;
  logic              ang_gt;
  logic [13:0]       rem_sh, trial;
  logic              sq_ge;
  logic [11:0]       rem_next;
  logic [4:0]        h;
  logic [5:0]        diff;
  logic [4:0]        turn_c;

  // Q0.8 cosine magnitude for multiples of 15 degrees, 0..90
  function automatic logic [8:0] cmag(input logic [3:0] k);
    case (k)
      4'd0:    cmag = 9'd256;
      4'd1:    cmag = 9'd247;
      4'd2:    cmag = 9'd222;
      4'd3:    cmag = 9'd181;
      4'd4:    cmag = 9'd128;
      4'd5:    cmag = 9'd66;
      default: cmag = 9'd0;
    endcase
  endfunction

  // 256*tan(7.5 + 15k deg): boundaries between neighbouring 15-degree sectors
  function automatic logic [10:0] tan_thr(input logic [3:0] k);
    case (k)
      4'd0:    tan_thr = 11'd34;
      4'd1:    tan_thr = 11'd106;
      4'd2:    tan_thr = 11'd196;
      4'd3:    tan_thr = 11'd334;
      4'd4:    tan_thr = 11'd618;
      default: tan_thr = 11'd1944;
    endcase
  endfunction

  // r * |trig| with the Q0.8 fraction dropped
  function automatic logic [7:0] scale(input logic [7:0] r, input logic [8:0] c);
    logic [15:0] p;
    p     = {8'd0, r} * {7'd0, c};
    scale = 8'(p >> 8);
  endfunction

  function automatic logic signed [8:0] to_x(input logic [7:0] r, input logic [3:0] t);
    if (t <= 4'd6) to_x = $signed({1'b0, scale(r, cmag(t))});
    else           to_x = -$signed({1'b0, scale(r, cmag(4'd12 - t))});
  endfunction

  // Theta never exceeds 180 deg, so y is never negative
  function automatic logic signed [8:0] to_y(input logic [7:0] r, input logic [3:0] t);
    if (t <= 4'd6) to_y = $signed({1'b0, scale(r, cmag(4'd6 - t))});
    else           to_y = $signed({1'b0, scale(r, cmag(t - 4'd6))});
  endfunction

  // Datapath: range check, polar->cartesian, magnitudes, sector test, sqrt step, quadrant mapping
  always_comb begin
    invalid   = (t_cur > 4'd11) || (t_tgt > 4'd11) || (orient > 5'd23);
    x_cur_c   = to_x(r_cur, t_cur);
    y_cur_c   = to_y(r_cur, t_cur);
    x_tgt_c   = to_x(r_tgt, t_tgt);
    y_tgt_c   = to_y(r_tgt, t_tgt);
    abs_dx    = dx[9] ? 9'(-dx) : 9'(dx);
    abs_dy    = dy[9] ? 9'(-dy) : 9'(dy);
    sq_c      = {11'd0, abs_dx} * {11'd0, abs_dx} + {11'd0, abs_dy} * {11'd0, abs_dy};
    dy_scaled = {3'd0, ady, 8'd0};
    dx_scaled = {11'd0, adx} * {9'd0, tan_thr(cnt)};
    ang_gt    = dy_scaled > dx_scaled;
    rem_sh    = {rem, sq_sh[19:18]};
    trial     = {2'd0, root, 2'b01};
    sq_ge     = rem_sh >= trial;
    rem_next  = sq_ge ? 12'(rem_sh - trial) : 12'(rem_sh);
    case ({dx_neg, dy_neg})
      2'b00:   h = {2'd0, s};
      2'b10:   h = 5'd12 - {2'd0, s};
      2'b11:   h = 5'd12 + {2'd0, s};
      default: h = (s == 3'd0) ? 5'd0 : 5'd24 - {2'd0, s};
    endcase
    // No displacement: keep the current heading so the turn is zero
    if (adx == 9'd0 && ady == 9'd0) h = orient;
    diff   = {1'b0, h} - {1'b0, orient};
    turn_c = diff[5] ? 5'(diff + 6'd24) : diff[4:0];
  end

  // Sequencer: one state per pipeline step, multi-cycle ANGLE and SQRT counted by cnt
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      turn     <= 5'd0;
      distance <= 10'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // A start coinciding with the done cycle is dropped
          if (enable && !done) begin
            r_cur  <= r_theta_current[7:0];
            t_cur  <= r_theta_current[11:8];
            r_tgt  <= r_theta_target[7:0];
            t_tgt  <= r_theta_target[11:8];
            orient <= orientation_current;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          error    <= invalid;
          turn     <= 5'd0;
          distance <= 10'd0;
          state    <= invalid ? REPORT : PTC;
        end
        PTC: begin
          x_cur <= x_cur_c;
          y_cur <= y_cur_c;
          x_tgt <= x_tgt_c;
          y_tgt <= y_tgt_c;
          state <= DELTA;
        end
        DELTA: begin
          dx    <= {x_tgt[8], x_tgt} - {x_cur[8], x_cur};
          dy    <= {y_tgt[8], y_tgt} - {y_cur[8], y_cur};
          state <= SQUARE;
        end
        SQUARE: begin
          adx    <= abs_dx;
          ady    <= abs_dy;
          dx_neg <= dx[9];
          dy_neg <= dy[9];
          sq_sh  <= sq_c;
          s      <= 3'd0;
          cnt    <= 4'd0;
          state  <= ANGLE;
        end
        ANGLE: begin
          if (ang_gt) s <= s + 3'd1;
          if (cnt == 4'd5) begin
            cnt   <= 4'd0;
            rem   <= 12'd0;
            root  <= 10'd0;
            state <= SQRT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SQRT: begin
          rem   <= rem_next;
          root  <= {root[8:0], sq_ge};
          sq_sh <= {sq_sh[17:0], 2'b00};
          if (cnt == 4'd9) state <= TURN;
          cnt <= cnt + 4'd1;
        end
        TURN: begin
          turn_r <= turn_c;
          state  <= REPORT;
        end
        REPORT: begin
          if (!error) begin
            turn     <= turn_r;
            distance <= root;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_math.sv
// tb_path_math: table vectors, randomized runs against a reference model, and multi-cycle corner sequences.
module tb_path_math;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] r_theta_current;
  logic [11:0] r_theta_target;
  logic [4:0]  orientation_current;
  logic        busy, done, error;
  logic [4:0]  turn;
  logic [9:0]  distance;

  path_math dut (
    .clock(clock), .reset(reset), .enable(enable),
    .r_theta_current(r_theta_current), .r_theta_target(r_theta_target),
    .orientation_current(orientation_current),
    .busy(busy), .done(done), .error(error), .turn(turn), .distance(distance)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: geometry from the trig table, integer floor sqrt by search
  int cm [7] = '{256, 247, 222, 181, 128, 66, 0};
  int th [6] = '{34, 106, 196, 334, 618, 1944};

  function automatic void polar(input int r, input int t, output int x, output int y);
    if (t <= 6) begin
      x = (r * cm[t]) / 256;
      y = (r * cm[6 - t]) / 256;
    end else begin
      x = -((r * cm[12 - t]) / 256);
      y = (r * cm[t - 6]) / 256;
    end
  endfunction

  function automatic void model(input int rc, input int tc, input int rt, input int tt, input int o,
                                output int et, output int ed, output int ee);
    int xc, yc, xt, yt, dx, dy, adx, ady, s, h, sq, d;
    et = 0; ed = 0;
    ee = (tc > 11 || tt > 11 || o > 23) ? 1 : 0;
    if (ee == 1) return;
    polar(rc, tc, xc, yc);
    polar(rt, tt, xt, yt);
    dx = xt - xc; dy = yt - yc;
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    s = 0;
    for (int k = 0; k < 6; k++) if (256 * ady > adx * th[k]) s++;
    if (dx == 0 && dy == 0) h = o;
    else if (dx >= 0 && dy >= 0) h = s;
    else if (dx < 0 && dy >= 0) h = 12 - s;
    else if (dx < 0) h = 12 + s;
    else h = (24 - s) % 24;
    et = ((h - o) % 24 + 24) % 24;
    sq = dx * dx + dy * dy;
    d = 0;
    while ((d + 1) * (d + 1) <= sq) d++;
    ed = d;
  endfunction

  // One operation: start from IDLE, scramble inputs while busy, wait for done (bounded)
  task automatic run_op(input int rc, input int tc, input int rt, input int tt, input int o,
                        output int lat, output int gt, output int gd, output int ge, output int gb);
    @(negedge clock);
    r_theta_current     = {4'(tc), 8'(rc)};
    r_theta_target      = {4'(tt), 8'(rt)};
    orientation_current = 5'(o);
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (done) break;
      r_theta_current     = 12'($urandom);
      r_theta_target      = 12'($urandom);
      orientation_current = 5'($urandom);
    end
    gt = turn; gd = distance; ge = error; gb = busy;
  endtask

  typedef struct {
    int rc, tc, rt, tt, o;
    int et, ed, ee, lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gt, gd, ge, gb, et, ed, ee, ndone, wait_cnt;
    int rc, tc, rt, tt, o;

    vecs[0] = '{100, 0, 100, 6, 0,   9, 141, 0, 22};
    vecs[1] = '{100, 6, 0, 0, 6,     12, 100, 0, 22};
    vecs[2] = '{0, 0, 200, 0, 20,    4, 200, 0, 22};
    vecs[3] = '{50, 3, 50, 3, 7,     0, 0, 0, 22};
    vecs[4] = '{100, 0, 100, 13, 0,  0, 0, 1, 2};
    vecs[5] = '{100, 0, 100, 6, 24,  0, 0, 1, 2};
    vecs[6] = '{100, 0, 100, 6, 0,   9, 141, 0, 22};
    vecs[7] = '{100, 12, 10, 0, 3,   0, 0, 1, 2};
    vecs[8] = '{255, 0, 255, 11, 23, 13, 505, 0, 22};
    vecs[9] = '{100, 3, 0, 0, 0,     15, 98, 0, 22};

    reset = 1'b1; enable = 1'b0;
    r_theta_current = '0; r_theta_target = '0; orientation_current = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_turn", turn, 0);
    chk("reset_distance", distance, 0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].rc, vecs[i].tc, vecs[i].rt, vecs[i].tt, vecs[i].o, lat, gt, gd, ge, gb);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_turn", i), gt, vecs[i].et);
      chk($sformatf("vec%0d_distance", i), gd, vecs[i].ed);
      chk($sformatf("vec%0d_error", i), ge, vecs[i].ee);
      chk($sformatf("vec%0d_busy_at_done", i), gb, 0);
    end

    // Randomized runs against the model, occasionally out of range
    for (int i = 0; i < 150; i++) begin
      rc = $urandom_range(0, 255);
      rt = $urandom_range(0, 255);
      tc = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 11);
      tt = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 11);
      o  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 23);
      if (i % 10 == 0) begin rt = rc; tt = tc; end
      model(rc, tc, rt, tt, o, et, ed, ee);
      run_op(rc, tc, rt, tt, o, lat, gt, gd, ge, gb);
      chk($sformatf("rnd%0d_latency", i), lat, (ee == 1) ? 2 : 22);
      chk($sformatf("rnd%0d_turn", i), gt, et);
      chk($sformatf("rnd%0d_distance", i), gd, ed);
      chk($sformatf("rnd%0d_error", i), ge, ee);
    end

    // enable held high: starts only from IDLE, one done per run
    @(negedge clock);
    r_theta_current = {4'd0, 8'd100}; r_theta_target = {4'd6, 8'd100}; orientation_current = 5'd0;
    enable = 1'b1;
    ndone = 0;
    for (int c = 0; c < 72; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) begin
        ndone++;
        chk("held_turn", turn, 9);
        chk("held_distance", distance, 141);
        chk("held_busy_low", busy, 0);
      end
    end
    enable = 1'b0;
    chk("held_done_count", ndone, 3);
    wait_cnt = 0;
    while ((busy || done) && wait_cnt < 40) begin
      @(negedge clock);
      wait_cnt++;
    end
    chk("held_drain_timeout", (wait_cnt >= 40) ? 1 : 0, 0);

    // Reset in the middle of SQRT aborts the run silently
    @(negedge clock);
    r_theta_current = {4'd0, 8'd100}; r_theta_target = {4'd6, 8'd100}; orientation_current = 5'd0;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    repeat (13) @(negedge clock);
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_error", error, 0);
    chk("abort_turn", turn, 0);
    chk("abort_distance", distance, 0);
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op(100, 0, 100, 6, 0, lat, gt, gd, ge, gb);
    chk("restart_latency", lat, 22);
    chk("restart_turn", gt, 9);
    chk("restart_distance", gd, 141);
    chk("restart_error", ge, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
